// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: data-island packet type codes and the pending-flag bundle
// shared by the packet scheduler and its priority selector.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL     = 8'h00;
    localparam logic [7:0] PKT_ACR      = 8'h01;
    localparam logic [7:0] PKT_AUDIO    = 8'h02;
    localparam logic [7:0] PKT_AVI_IF   = 8'h82;
    localparam logic [7:0] PKT_AUDIO_IF = 8'h84;

    // One bit per packet kind that must eventually be sent.
    typedef struct packed {
        logic acr;
        logic avi;
        logic aif;
    } pending_t;

endpackage

// File: rtl/packet_scheduler_if.sv
// packet_scheduler_if: raster position, audio fill level and packet slot
// signals between the hdmi core / audio buffer (master) and the scheduler (slave).
interface packet_scheduler_if #(
    parameter int unsigned BIT_WIDTH  = 10,
    parameter int unsigned BIT_HEIGHT = 10
);
    logic [BIT_WIDTH-1:0]  cx;
    logic [BIT_HEIGHT-1:0] cy;
    logic                  packet_enable;
    logic [7:0]            remaining;
    logic [7:0]            packet_type;
    logic                  audio_pop;
    logic [7:0]            missed_count;

    modport master (
        output cx, cy, packet_enable, remaining,
        input  packet_type, audio_pop, missed_count
    );

    modport slave (
        input  cx, cy, packet_enable, remaining,
        output packet_type, audio_pop, missed_count
    );
endinterface

// File: rtl/packet_priority_select.sv
// packet_priority_select: fixed-priority choice of the next packet type from
// the pending flags, the audio-run hold condition and audio eligibility.
module packet_priority_select
    import hdmi_packet_pkg::*;
(
    input  pending_t   pending,
    input  logic       run_hold,
    input  logic       audio_ok,
    output logic [7:0] packet_type_c
);
    // ACR first; InfoFrames only once audio has had its run or has nothing to send.
    always_comb begin
        packet_type_c = PKT_NULL;
        if (pending.acr) begin
            packet_type_c = PKT_ACR;
        end else if (pending.avi && run_hold) begin
            packet_type_c = PKT_AVI_IF;
        end else if (pending.aif && run_hold) begin
            packet_type_c = PKT_AUDIO_IF;
        end else if (audio_ok) begin
            packet_type_c = PKT_AUDIO;
        end
    end
endmodule

// File: rtl/packet_scheduler.sv
// packet_scheduler: picks the data-island packet type offered to hdmi on each
// packet_enable slot (ACR, audio, AVI/Audio InfoFrame, null).
// Optional build macro PACKET_SCHEDULER_STATS_EN: counts frames that started
// with an InfoFrame still unsent; without it missed_count is tied to zero.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int unsigned BIT_WIDTH     = 10,
    parameter int unsigned BIT_HEIGHT    = 10,
    parameter int unsigned ACR_LINES     = 16,
    parameter int unsigned AUDIO_MIN     = 1,
    parameter int unsigned MAX_AUDIO_RUN = 4
) (
    input  logic              clk_pixel,
    input  logic              reset,
    packet_scheduler_if.slave bus
);
    localparam int unsigned LINE_W     = (ACR_LINES > 1) ? $clog2(ACR_LINES) : 1;
    localparam int unsigned RUN_NEED_W = $clog2(MAX_AUDIO_RUN + 1);
    localparam int unsigned RUN_W      = (RUN_NEED_W > 3) ? RUN_NEED_W : 3;

    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ACR_LINES - 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(MAX_AUDIO_RUN);
    localparam logic [8:0]        FILL_MIN  = 9'(AUDIO_MIN);

    logic              line_stb;
    logic              frame_stb;
    logic              commit;
    logic              inflight;
    logic              count_low;
    logic              audio_ok;
    logic              run_hold;
    logic [7:0]        fill_eff;
    pending_t          pend_q;
    pending_t          pend_n;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_n;
    logic [RUN_W-1:0]  run_q;
    logic [RUN_W-1:0]  run_n;
    logic [7:0]        pkt_q;
    logic [7:0]        pkt_c;
    logic              pop_q;

    // Raster strobes and slot commit.
    always_comb begin
        line_stb  = (bus.cx == BIT_WIDTH'(0));
        frame_stb = line_stb && (bus.cy == BIT_HEIGHT'(0));
        commit    = bus.packet_enable;
    end

    // Next pending flags, line counter and audio run; sets override same-cycle clears.
    always_comb begin
        pend_n = pend_q;
        line_n = line_q;
        run_n  = run_q;
        if (commit) begin
            case (pkt_q)
                PKT_ACR: begin
                    pend_n.acr = 1'b0;
                    run_n      = '0;
                end
                PKT_AVI_IF: begin
                    pend_n.avi = 1'b0;
                    run_n      = '0;
                end
                PKT_AUDIO_IF: begin
                    pend_n.aif = 1'b0;
                    run_n      = '0;
                end
                PKT_AUDIO: begin
                    if (run_q != '1) begin
                        run_n = run_q + RUN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
        if (frame_stb) begin
            pend_n = '1;
            line_n = '0;
        end else if (line_stb) begin
            if (line_q == LINE_LAST) begin
                pend_n.acr = 1'b1;
                line_n     = '0;
            end else begin
                line_n = line_q + LINE_W'(1);
            end
        end
    end

    // Audio eligibility against the fill level net of a pop the buffer has not yet seen.
    always_comb begin
        inflight  = pop_q || (commit && (pkt_q == PKT_AUDIO));
        fill_eff  = (inflight && (bus.remaining != 8'd0)) ? bus.remaining - 8'd1 : bus.remaining;
        count_low = ({1'b0, fill_eff} < FILL_MIN);
        audio_ok  = !inflight && !count_low && (bus.remaining != 8'd0);
        run_hold  = (run_n >= RUN_LIMIT) || count_low;
    end

    packet_priority_select u_select (
        .pending       (pend_n),
        .run_hold      (run_hold),
        .audio_ok      (audio_ok),
        .packet_type_c (pkt_c)
    );

    // State and output registers.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            line_q <= '0;
            run_q  <= '0;
            pkt_q  <= PKT_NULL;
            pop_q  <= 1'b0;
        end else begin
            pend_q <= pend_n;
            line_q <= line_n;
            run_q  <= run_n;
            pkt_q  <= pkt_c;
            pop_q  <= commit && (pkt_q == PKT_AUDIO);
        end
    end

    assign bus.packet_type = pkt_q;
    assign bus.audio_pop   = pop_q;

`ifdef PACKET_SCHEDULER_STATS_EN
    logic [7:0] missed_q;

    // Count frames that begin with an InfoFrame still pending, saturating.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            missed_q <= 8'd0;
        end else if (frame_stb && (pend_q.avi || pend_q.aif) && (missed_q != 8'hFF)) begin
            missed_q <= missed_q + 8'd1;
        end
    end

    assign bus.missed_count = missed_q;
`else
    assign bus.missed_count = 8'd0;
`endif
endmodule
